// File: rtl/rg_bit_collector.sv
`default_nettype none
// ============================================================================
//  Module   : rg_bit_collector
//  Purpose  : Samples the ring-generator serial bitstream, optionally debiases
//             it with a von Neumann pair corrector, packs WIDTH-bit words into
//             a valid/ready holding register and runs a repetition-count test.
//  Revision : 1.0
// ============================================================================
module rg_bit_collector #(
    parameter int WIDTH     = 32,
    parameter int DEBIAS    = 1,
    parameter int RCT_LIMIT = 31
) (
    input  logic             iClk,
    input  logic             iRst,
    input  logic             iEn,
    input  logic             iSample,
    input  logic             iSerial,
    input  logic             iClear,
    input  logic             iReady,
    output logic             oValid,
    output logic [WIDTH-1:0] oData,
    output logic             oAlarm,
    output logic             oOverflow
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam int RUN_W = $clog2(RCT_LIMIT + 1);

    localparam logic [CNT_W-1:0] c_LAST_BIT  = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] c_CNT_ONE   = CNT_W'(1);
    localparam logic [RUN_W-1:0] c_RUN_LIMIT = RUN_W'(RCT_LIMIT);
    localparam logic [RUN_W-1:0] c_RUN_ONE   = RUN_W'(1);

    typedef enum logic [0:0] {
        c_IDLE = 1'b0,
        c_HALF = 1'b1
    } pairState_t;

    logic             r_valid;
    logic [WIDTH-1:0] r_data;
    logic             r_alarm;
    logic             r_overflow;
    logic [WIDTH-1:0] r_acc;
    logic [CNT_W-1:0] r_bitCnt;
    logic [RUN_W-1:0] r_run;
    logic             r_lastBit;

    logic             w_sample;
    logic             w_emitRaw;
    logic             w_emitBit;
    logic             w_emit;
    logic             w_wordDone;
    logic [WIDTH-1:0] w_accNext;
    logic [RUN_W-1:0] w_runNext;

    // iClear wins over a coincident sample
    assign w_sample   = iEn & iSample & ~iClear;
    assign w_emit     = w_emitRaw & ~r_alarm;
    assign w_accNext  = {w_emitBit, r_acc[WIDTH-1:1]};
    assign w_wordDone = w_emit & (r_bitCnt == c_LAST_BIT);

    generate
        if (DEBIAS != 0) begin : g_debias
            pairState_t r_state;
            pairState_t w_stateNext;
            logic       r_held;
            logic       w_heldNext;

            always_ff @(posedge iClk or posedge iRst) begin
                if (iRst) begin
                    r_state <= c_IDLE;
                    r_held  <= 1'b0;
                end else begin
                    r_state <= w_stateNext;
                    r_held  <= w_heldNext;
                end
            end

            // 01 -> 0, 10 -> 1, equal pairs are discarded
            always_comb begin
                w_stateNext = r_state;
                w_heldNext  = r_held;
                w_emitRaw   = 1'b0;
                w_emitBit   = r_held;
                if (iClear || r_alarm) begin
                    w_stateNext = c_IDLE;
                end else if (w_sample) begin
                    case (r_state)
                        c_IDLE: begin
                            w_heldNext  = iSerial;
                            w_stateNext = c_HALF;
                        end
                        c_HALF: begin
                            w_emitRaw   = (r_held != iSerial);
                            w_stateNext = c_IDLE;
                        end
                        default: w_stateNext = c_IDLE;
                    endcase
                end
            end
        end else begin : g_raw
            assign w_emitRaw = w_sample;
            assign w_emitBit = iSerial;
        end
    endgenerate

    // Packing: the first emitted bit of a word ends up in bit 0
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            r_acc    <= '0;
            r_bitCnt <= '0;
        end else begin
            if (iClear || r_alarm) begin
                r_bitCnt <= '0;
            end else if (w_emit) begin
                r_bitCnt <= (r_bitCnt == c_LAST_BIT) ? '0 : r_bitCnt + c_CNT_ONE;
            end
            if (w_emit) begin
                r_acc <= w_accNext;
            end
        end
    end

    // Single-entry holding register; a word arriving while full and not
    // being drained is dropped and flagged
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            r_valid    <= 1'b0;
            r_data     <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_wordDone) begin
                if (!r_valid || iReady) begin
                    r_data  <= w_accNext;
                    r_valid <= 1'b1;
                end else begin
                    r_overflow <= 1'b1;
                end
            end else if (r_valid && iReady) begin
                r_valid <= 1'b0;
            end
            if (iClear) begin
                r_overflow <= 1'b0;
            end
        end
    end

    always_comb begin
        w_runNext = c_RUN_ONE;
        if ((iSerial == r_lastBit) && (r_run != '0)) begin
            w_runNext = (r_run == c_RUN_LIMIT) ? r_run : r_run + c_RUN_ONE;
        end
    end

    // Repetition-count test on raw bits, independent of debiasing
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            r_run     <= '0;
            r_lastBit <= 1'b0;
            r_alarm   <= 1'b0;
        end else if (iClear) begin
            r_run   <= '0;
            r_alarm <= 1'b0;
        end else if (w_sample) begin
            r_run     <= w_runNext;
            r_lastBit <= iSerial;
            if (w_runNext == c_RUN_LIMIT) begin
                r_alarm <= 1'b1;
            end
        end
    end

    assign oValid    = r_valid;
    assign oData     = r_data;
    assign oAlarm    = r_alarm;
    assign oOverflow = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_rg_bit_collector.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rg_bit_collector
//  Purpose  : Directed self-checking bench for rg_bit_collector with a word
//             scoreboard popped on every output transfer.
//  Revision : 1.0
// ============================================================================
module tb_rg_bit_collector;

    logic        iClk;
    logic        iRst;
    logic        iEn;
    logic        iSample;
    logic        iSerial;
    logic        iClear;
    logic        iReady;
    logic        oValid;
    logic [31:0] oData;
    logic        oAlarm;
    logic        oOverflow;

    int          total;
    int          bad;
    int          validCycles;
    logic [31:0] q[$];

    rg_bit_collector #(
        .WIDTH    (32),
        .DEBIAS   (1),
        .RCT_LIMIT(31)
    ) dut (
        .iClk     (iClk),
        .iRst     (iRst),
        .iEn      (iEn),
        .iSample  (iSample),
        .iSerial  (iSerial),
        .iClear   (iClear),
        .iReady   (iReady),
        .oValid   (oValid),
        .oData    (oData),
        .oAlarm   (oAlarm),
        .oOverflow(oOverflow)
    );

    initial iClk = 1'b0;
    always #5 iClk = ~iClk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Inputs are set at the falling edge; a transfer seen here happens at the next rising edge
    task automatic tick();
        logic [31:0] expWord;
        if (oValid === 1'b1) validCycles++;
        if (oValid === 1'b1 && iReady === 1'b1) begin
            total++;
            assert (q.size() > 0)
            else begin
                bad++;
                $error("FAIL unexpected_word observed=%h expected=none", oData);
            end
            if (q.size() > 0) begin
                expWord = q.pop_front();
                check("word", oData, expWord);
            end
        end
        @(posedge iClk);
        @(negedge iClk);
    endtask

    task automatic sample(input logic b);
        iEn     = 1'b1;
        iSample = 1'b1;
        iSerial = b;
        tick();
        iSample = 1'b0;
    endtask

    task automatic pair(input logic a, input logic b);
        sample(a);
        sample(b);
    endtask

    // pairs alternating 01,10 -> 0xAAAAAAAA per 32 pairs
    task automatic altPairs(input int n);
        for (int i = 0; i < n; i++) begin
            if (i % 2 == 0) pair(1'b0, 1'b1);
            else            pair(1'b1, 1'b0);
        end
    endtask

    task automatic pulseClear();
        iClear = 1'b1;
        tick();
        iClear = 1'b0;
    endtask

    initial begin
        total = 0;
        bad = 0;
        validCycles = 0;
        iRst = 1'b1;
        iEn = 1'b0;
        iSample = 1'b0;
        iSerial = 1'b0;
        iClear = 1'b0;
        iReady = 1'b1;
        #1;
        check("reset_valid", {31'd0, oValid}, 32'd0);
        check("reset_data", oData, 32'd0);
        check("reset_alarm", {31'd0, oAlarm}, 32'd0);
        check("reset_ovf", {31'd0, oOverflow}, 32'd0);
        @(negedge iClk);
        @(negedge iClk);
        iRst = 1'b0;
        tick();

        // 1: 64 alternating-pair samples produce one word
        q.push_back(32'hAAAA_AAAA);
        validCycles = 0;
        altPairs(32);
        tick();
        tick();
        check("t1_valid_cycles", validCycles, 1);
        check("t1_queue_empty", q.size(), 0);
        check("t1_ovf", {31'd0, oOverflow}, 32'd0);
        check("t1_alarm", {31'd0, oAlarm}, 32'd0);

        // 2: equal pairs only -> nothing emitted
        validCycles = 0;
        for (int i = 0; i < 40; i++) begin
            if (i % 2 == 0) pair(1'b0, 1'b0);
            else            pair(1'b1, 1'b1);
        end
        tick();
        check("t2_valid_cycles", validCycles, 0);
        check("t2_alarm", {31'd0, oAlarm}, 32'd0);

        // 3: backpressure, second word dropped
        iReady = 1'b0;
        q.push_back(32'hAAAA_AAAA);
        altPairs(32);
        check("t3_valid_first", {31'd0, oValid}, 32'd1);
        check("t3_data_first", oData, 32'hAAAA_AAAA);
        check("t3_ovf_first", {31'd0, oOverflow}, 32'd0);
        for (int i = 0; i < 32; i++) begin
            if (i % 2 == 0) pair(1'b1, 1'b0);
            else            pair(1'b0, 1'b1);
        end
        check("t3_valid_held", {31'd0, oValid}, 32'd1);
        check("t3_data_held", oData, 32'hAAAA_AAAA);
        check("t3_ovf_set", {31'd0, oOverflow}, 32'd1);
        iReady = 1'b1;
        tick();
        check("t3_valid_drained", {31'd0, oValid}, 32'd0);
        check("t3_queue_empty", q.size(), 0);
        pulseClear();
        check("t3_ovf_cleared", {31'd0, oOverflow}, 32'd0);

        // 4: completion coincides with a transfer
        iReady = 1'b0;
        q.push_back(32'hAAAA_AAAA);
        q.push_back(32'h5555_5555);
        altPairs(32);
        for (int i = 0; i < 31; i++) begin
            if (i % 2 == 0) pair(1'b1, 1'b0);
            else            pair(1'b0, 1'b1);
        end
        sample(1'b0);
        iReady = 1'b1;
        sample(1'b1);
        check("t4_valid_kept", {31'd0, oValid}, 32'd1);
        check("t4_data_new", oData, 32'h5555_5555);
        check("t4_ovf", {31'd0, oOverflow}, 32'd0);
        tick();
        check("t4_queue_empty", q.size(), 0);
        check("t4_valid_drained", {31'd0, oValid}, 32'd0);

        // 5: stuck source raises the alarm
        pulseClear();
        for (int i = 0; i < 30; i++) sample(1'b1);
        check("t5_alarm_before", {31'd0, oAlarm}, 32'd0);
        sample(1'b1);
        check("t5_alarm_set", {31'd0, oAlarm}, 32'd1);
        validCycles = 0;
        altPairs(32);
        tick();
        check("t5_no_word", validCycles, 0);
        check("t5_alarm_sticky", {31'd0, oAlarm}, 32'd1);
        pulseClear();
        check("t5_alarm_cleared", {31'd0, oAlarm}, 32'd0);
        q.push_back(32'hAAAA_AAAA);
        altPairs(32);
        tick();
        check("t5_queue_empty", q.size(), 0);

        // 6: asynchronous reset mid-word with a pending word
        iReady = 1'b0;
        for (int i = 0; i < 32; i++) pair(1'b1, 1'b0);
        check("t6_pending", {31'd0, oValid}, 32'd1);
        for (int i = 0; i < 10; i++) pair(1'b1, 1'b0);
        #2;
        iRst = 1'b1;
        #1;
        check("t6_rst_valid", {31'd0, oValid}, 32'd0);
        check("t6_rst_data", oData, 32'd0);
        check("t6_rst_alarm", {31'd0, oAlarm}, 32'd0);
        check("t6_rst_ovf", {31'd0, oOverflow}, 32'd0);
        @(negedge iClk);
        iRst = 1'b0;
        iReady = 1'b1;
        tick();
        q.push_back(32'hFFFF_FFFF);
        for (int i = 0; i < 32; i++) pair(1'b1, 1'b0);
        tick();
        tick();
        check("t6_queue_empty", q.size(), 0);
        check("t6_ovf", {31'd0, oOverflow}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
